// File: rtl/cs161_mc_datapath.sv
// rtl/cs161_mc_datapath.sv - multi-cycle MIPS-subset core with a unified req/ready memory port
//
// Purpose: fetch/decode/exec/mem/writeback machine over one shared memory port.
// Optional feature macro: CS161_MC_TRAP_EN (unknown opcode/funct halts with trap=1;
// when undefined, unknown instructions retire as NOPs and trap is tied 0).
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   mem_req/mem_we      memory request and write qualifier
//   mem_addr/mem_wdata  byte address and store data
//   mem_ready/mem_rdata completion handshake and read data
//   prog_count, instr_opcode, state, write_reg_en/addr/data  debug taps
//   instr_retired       one-cycle pulse in the last cycle of each instruction
//   trap                illegal-instruction halt flag
module cs161_mc_datapath #(
  parameter int          WORD_SIZE = 32,
  parameter logic [63:0] RESET_PC  = 64'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ready,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [WORD_SIZE-1:0] prog_count,
  output logic [5:0]           instr_opcode,
  output logic [2:0]           state,
  output logic                 write_reg_en,
  output logic [4:0]           write_reg_addr,
  output logic [WORD_SIZE-1:0] write_reg_data,
  output logic                 instr_retired,
  output logic                 trap
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
                         OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;

  logic [2:0]           cur_state, next_state;
  logic [WORD_SIZE-1:0] pc, a_reg, b_reg, alu_out, mdr;
  logic [31:0]          ir;
  logic [WORD_SIZE-1:0] regs [32];

  // Instruction field decode
  logic [5:0]           opcode, funct;
  logic [4:0]           rs, rt, rd;
  logic [WORD_SIZE-1:0] imm_sext, br_off, alu_res, wb_data;
  logic [4:0]           wb_addr;
  logic                 is_r, is_addi, is_lw, is_sw, is_beq, is_j, known;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{(WORD_SIZE-16){ir[15]}}, ir[15:0]};
  assign br_off   = {imm_sext[WORD_SIZE-3:0], 2'b00};

  assign is_r    = (opcode == OP_RTYPE) &&
                   (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                    funct == 6'h25 || funct == 6'h2A);
  assign is_addi = (opcode == OP_ADDI);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);
  assign known   = is_r || is_addi || is_lw || is_sw || is_beq || is_j;

  // R-type ALU; slt compares as signed and zero-extends the 1-bit result
  always_comb begin
    alu_res = '0;
    case (funct)
      6'h20:   alu_res = a_reg + b_reg;
      6'h22:   alu_res = a_reg - b_reg;
      6'h24:   alu_res = a_reg & b_reg;
      6'h25:   alu_res = a_reg | b_reg;
      6'h2A:   alu_res = {{(WORD_SIZE-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
      default: alu_res = '0;
    endcase
  end

  // R-type writes rd; addi and lw write rt
  assign wb_addr = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_data = is_lw ? mdr : alu_out;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= S_FETCH;
    else     cur_state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        if (is_r || is_addi)     next_state = S_WB;
        else if (is_lw || is_sw) next_state = S_MEM;
        else if (is_beq || is_j) next_state = S_FETCH;
        else begin
`ifdef CS161_MC_TRAP_EN
          next_state = S_HALT;
`else
          next_state = S_FETCH;
`endif
        end
      end
      S_MEM:    if (mem_ready) next_state = is_lw ? S_WB : S_FETCH;
      S_WB:     next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  // Outputs; everything is forced low while reset is asserted so an
  // in-flight request is dropped in the same cycle
  always_comb begin
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    write_reg_en   = 1'b0;
    write_reg_addr = '0;
    write_reg_data = '0;
    instr_retired  = 1'b0;
    trap           = 1'b0;
    prog_count     = pc;
    instr_opcode   = opcode;
    state          = cur_state;
    if (!rst) begin
      case (cur_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc;
        end
        S_EXEC: begin
`ifdef CS161_MC_TRAP_EN
          instr_retired = is_beq || is_j;
`else
          instr_retired = is_beq || is_j || !known;
`endif
        end
        S_MEM: begin
          mem_req       = 1'b1;
          mem_addr      = alu_out;
          mem_we        = is_sw;
          mem_wdata     = is_sw ? b_reg : '0;
          instr_retired = is_sw && mem_ready;
        end
        S_WB: begin
          write_reg_en   = 1'b1;
          write_reg_addr = wb_addr;
          write_reg_data = wb_data;
          instr_retired  = 1'b1;
        end
        S_HALT: begin
`ifdef CS161_MC_TRAP_EN
          trap = 1'b1;
`else
          trap = 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  // Datapath registers and register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC[WORD_SIZE-1:0];
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (cur_state)
        S_FETCH: if (mem_ready) begin
          ir <= mem_rdata[31:0];
          pc <= pc + WORD_SIZE'(4);
        end
        S_DECODE: begin
          a_reg   <= regs[rs];
          b_reg   <= regs[rt];
          alu_out <= pc + br_off;
        end
        S_EXEC: begin
          if (is_r)                           alu_out <= alu_res;
          else if (is_addi || is_lw || is_sw) alu_out <= a_reg + imm_sext;
          else if (is_beq && a_reg == b_reg)  pc      <= alu_out;
          else if (is_j)                      pc      <= {pc[WORD_SIZE-1:28], ir[25:0], 2'b00};
        end
        S_MEM: if (mem_ready && is_lw) mdr <= mem_rdata;
        S_WB:  if (wb_addr != 5'd0) regs[wb_addr] <= wb_data;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cs161_mc_datapath.sv
// tb/tb_cs161_mc_datapath.sv - self-checking bench for cs161_mc_datapath
module tb_cs161_mc_datapath;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, prog_count, write_reg_data;
  logic [5:0]  instr_opcode;
  logic [2:0]  state;
  logic        write_reg_en, instr_retired, trap;
  logic [4:0]  write_reg_addr;

  cs161_mc_datapath #(.WORD_SIZE(32), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .prog_count(prog_count), .instr_opcode(instr_opcode), .state(state),
    .write_reg_en(write_reg_en), .write_reg_addr(write_reg_addr),
    .write_reg_data(write_reg_data), .instr_retired(instr_retired), .trap(trap));

  always #5 clk = ~clk;

  // Memory: 256 words, image copied in while reset is held
  logic [31:0] img [256];
  logic [31:0] mem [256];
  int          wcnt, rnd_target, fetch_waits = 0, data_waits = 0;
  bit          rand_mode = 1'b0;
  logic [31:0] last_waddr, last_wdata;

  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ready = (wcnt >= (rand_mode ? rnd_target :
                               (state == 3'd3 ? data_waits : fetch_waits)));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt       <= 0;
      rnd_target <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (mem_req) begin
      if (mem_ready) begin
        wcnt       <= 0;
        rnd_target <= $urandom_range(0, 2);
        if (mem_we) begin
          mem[mem_addr[9:2]] <= mem_wdata;
          last_waddr         <= mem_addr;
          last_wdata         <= mem_wdata;
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // Bookkeeping and reference ISA model
  int          n_pass = 0, n_total = 0;
  int          cyc, waits, retire_count, last_cyc;
  bit          pc_pending;
  logic [4:0]  last_wr_addr;
  logic [31:0] last_wr_data;
  logic [31:0] model_pc;
  logic [31:0] model_reg [32];
  logic [31:0] model_mem [256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] sx(input logic [15:0] i);
    return {{16{i[15]}}, i};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction

  function automatic logic [31:0] enc_j(input int addr);
    return {6'd2, addr[27:2]};
  endfunction

  // One instruction at ISA level: returns the expected register write and base cycle count
  task automatic model_step(output logic we, output logic [4:0] wa, output logic [31:0] wd,
                            output int base);
    logic [31:0] ins, a, b, npc, addr;
    ins = model_mem[model_pc[9:2]];
    a = model_reg[ins[25:21]];
    b = model_reg[ins[20:16]];
    npc = model_pc + 32'd4;
    addr = a + sx(ins[15:0]);
    we = 1'b0; wa = 5'd0; wd = 32'd0; base = 3;
    case (ins[31:26])
      6'h00: begin
        we = 1'b1; wa = ins[15:11]; base = 4;
        case (ins[5:0])
          6'h20: wd = a + b;
          6'h22: wd = a - b;
          6'h24: wd = a & b;
          6'h25: wd = a | b;
          6'h2A: wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin we = 1'b0; wa = 5'd0; base = 3; end
        endcase
      end
      6'h08: begin we = 1'b1; wa = ins[20:16]; wd = addr; base = 4; end
      6'h23: begin we = 1'b1; wa = ins[20:16]; wd = model_mem[addr[9:2]]; base = 5; end
      6'h2B: begin model_mem[addr[9:2]] = b; base = 4; end
      6'h04: if (a == b) npc = npc + (sx(ins[15:0]) << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    if (we && wa != 5'd0) model_reg[wa] = wd;
    model_pc = npc;
  endtask

  task automatic monitor_loop();
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    int          base;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; waits = 0; pc_pending = 1'b0; retire_count = 0;
        model_pc = 32'd0;
        for (int i = 0; i < 32; i++) model_reg[i] = 32'd0;
        for (int i = 0; i < 256; i++) model_mem[i] = img[i];
      end else begin
        if (pc_pending) begin
          check("pc_after_retire", prog_count, model_pc);
          pc_pending = 1'b0;
        end
        cyc++;
        if (mem_req && !mem_ready) waits++;
        if (write_reg_en) begin
          last_wr_addr = write_reg_addr;
          last_wr_data = write_reg_data;
        end
        if (instr_retired) begin
          model_step(ewe, ewa, ewd, base);
          check("wr_en", write_reg_en, ewe);
          if (ewe) begin
            check("wr_addr", write_reg_addr, ewa);
            check("wr_data", write_reg_data, ewd);
          end
          check("instr_cycles", cyc, base + waits);
          last_cyc = cyc;
          cyc = 0; waits = 0; pc_pending = 1'b1;
          retire_count++;
        end
      end
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_retires(input int n, input int budget);
    int  target;
    bit  done;
    target = retire_count + n;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (retire_count >= target) begin done = 1'b1; break; end
    end
    check("retire_budget", done, 1'b1);
  endtask

  typedef struct {
    int          fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;
  alu_vec_t vecs [10];

  initial begin
    bit saw_req;
    int mism, kind, tgt, off;
    vecs[0] = '{32'h20, 32'd7,          32'd8,          32'd15};
    vecs[1] = '{32'h20, 32'hFFFF_FFFF,  32'd1,          32'd0};
    vecs[2] = '{32'h22, 32'd0,          32'd1,          32'hFFFF_FFFF};
    vecs[3] = '{32'h22, 32'd10,         32'd3,          32'd7};
    vecs[4] = '{32'h24, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000};
    vecs[5] = '{32'h25, 32'h0F0F_0000,  32'h0000_00FF,  32'h0F0F_00FF};
    vecs[6] = '{32'h2A, 32'hFFFF_FFFD,  32'd5,          32'd1};
    vecs[7] = '{32'h2A, 32'd5,          32'hFFFF_FFFD,  32'd0};
    vecs[8] = '{32'h2A, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1};
    vecs[9] = '{32'h2A, 32'd3,          32'd3,          32'd0};

    fork monitor_loop(); join_none

    // Reset during a stalled fetch
    clear_img();
    img[0] = enc_i(8, 0, 1, 5);
    img[1] = enc_j(4);
    fetch_waits = 100;
    do_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("fetch_req_held", mem_req, 1'b1);
    check("fetch_addr", mem_addr, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("rst_drops_req", mem_req, 1'b0);
    check("rst_wr_en", write_reg_en, 1'b0);
    check("rst_retired", instr_retired, 1'b0);
    fetch_waits = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_pc", prog_count, 32'd0);
    check("post_rst_state", state, 3'd0);
    check("post_rst_opcode", instr_opcode, 6'd0);

    // addi/addi/add with ready tied high: $3 written in cycle 12
    clear_img();
    img[0] = enc_i(8, 0, 1, 5);
    img[1] = enc_i(8, 0, 2, 32'hFFFD);
    img[2] = enc_r(1, 2, 3, 32'h20);
    img[3] = enc_j(32'h0C);
    do_reset();
    for (int k = 1; k <= 12; k++) @(negedge clk);
    check("c12_wr_en", write_reg_en, 1'b1);
    check("c12_wr_addr", write_reg_addr, 5'd3);
    check("c12_wr_data", write_reg_data, 32'd2);
    @(posedge clk);
    check("c12_retires", retire_count, 3);

    // sw then lw with two wait states on each data access
    clear_img();
    img[0]  = enc_j(32'h40);
    img[16] = enc_i(8, 0, 1, 5);
    img[17] = enc_i(32'h2B, 0, 1, 8);
    img[18] = enc_i(32'h23, 0, 4, 8);
    img[19] = enc_j(32'h4C);
    data_waits = 2;
    do_reset();
    run_retires(4, 100);
    check("sw_addr", last_waddr, 32'd8);
    check("sw_data", last_wdata, 32'd5);
    check("lw_dest", last_wr_addr, 5'd4);
    check("lw_data", last_wr_data, 32'd5);
    check("lw_cycles", last_cyc, 7);
    data_waits = 0;

    // beq taken onto itself
    clear_img();
    img[0] = enc_i(8, 0, 1, 1);
    img[4] = enc_i(4, 1, 1, 32'hFFFF);
    for (int i = 1; i < 4; i++) img[i] = enc_i(8, 0, 0, 0);
    do_reset();
    run_retires(4, 60);
    for (int k = 0; k < 3; k++) begin
      run_retires(1, 20);
      @(negedge clk);
      check("beq_loop_pc", prog_count, 32'h10);
      check("beq_cycles", last_cyc, 3);
    end

    // beq not taken
    img[4] = enc_i(4, 1, 2, 32'hFFFF);
    img[5] = enc_j(32'h14);
    do_reset();
    run_retires(5, 60);
    @(negedge clk);
    check("beq_nt_pc", prog_count, 32'h14);

    // ALU vectors: operands loaded from memory, R-type result into $5
    for (int v = 0; v < 10; v++) begin
      clear_img();
      img[0]   = enc_i(32'h23, 0, 1, 32'h200);
      img[1]   = enc_i(32'h23, 0, 2, 32'h204);
      img[2]   = enc_r(1, 2, 5, vecs[v].fn);
      img[3]   = enc_j(32'h0C);
      img[128] = vecs[v].a;
      img[129] = vecs[v].b;
      do_reset();
      run_retires(3, 60);
      check($sformatf("alu%0d_dest", v), last_wr_addr, 5'd5);
      check($sformatf("alu%0d_data", v), last_wr_data, vecs[v].exp);
    end

    // Unknown opcode 0x3F
    clear_img();
    img[0] = 32'hFC00_0000;
    img[1] = enc_j(32'h04);
    do_reset();
`ifdef CS161_MC_TRAP_EN
    repeat (3) @(negedge clk);
    saw_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_req) saw_req = 1'b1;
    end
    check("halt_trap", trap, 1'b1);
    check("halt_state", state, 3'd5);
    check("halt_no_req", saw_req, 1'b0);
    check("halt_pc", prog_count, 32'd4);
`else
    run_retires(1, 20);
    @(negedge clk);
    check("nop_pc", prog_count, 32'd4);
    check("nop_cycles", last_cyc, 3);
    check("nop_trap", trap, 1'b0);
`endif

    // Randomized program with random wait states against the ISA model
    clear_img();
    for (int i = 128; i < 256; i++) img[i] = $urandom;
    for (int i = 0; i < 127; i++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1: img[i] = enc_i(8, $urandom_range(0, 7), $urandom_range(1, 7), $urandom);
        2, 3, 4: img[i] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 7),
                              ($urandom_range(0, 4) == 0) ? 32'h20 :
                              ($urandom_range(0, 3) == 0) ? 32'h22 :
                              ($urandom_range(0, 2) == 0) ? 32'h24 :
                              ($urandom_range(0, 1) == 0) ? 32'h25 : 32'h2A);
        5, 6: img[i] = enc_i(32'h23, 0, $urandom_range(1, 7), 32'h200 + 4 * $urandom_range(0, 127));
        7: img[i] = enc_i(32'h2B, 0, $urandom_range(0, 7), 32'h200 + 4 * $urandom_range(0, 127));
        8: begin
          off = $urandom_range(0, 6) - 3;
          tgt = i + 1 + off;
          if (tgt < 0 || tgt > 127) off = 0;
          img[i] = enc_i(4, $urandom_range(0, 7), $urandom_range(0, 7), off);
        end
        default: img[i] = enc_j(4 * $urandom_range(0, 127));
      endcase
    end
    img[127] = enc_j(0);
    rand_mode = 1'b1;
    do_reset();
    run_retires(400, 6000);
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== model_mem[i]) mism++;
    check("mem_image", mism, 0);
    rand_mode = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
